// File: rtl/multi_ch_gray_sync.sv
// Multi-channel gray-pointer synchroniser: brings CHANNELS gray pointers into dest_clk,
// converts them to binary and reports per-channel updates, deltas and illegal jumps.
module multi_ch_gray_sync #(
    parameter int SIZE     = 4,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 2
) (
    input  logic                     dest_clk,
    input  logic                     rst_n,
    input  logic [CHANNELS*SIZE-1:0] gray_in,
    input  logic [CHANNELS-1:0]      err_clr,
    output logic                     sync_ready,
    output logic [CHANNELS*SIZE-1:0] bin_out,
    output logic [CHANNELS-1:0]      update,
    output logic [CHANNELS*SIZE-1:0] delta,
    output logic [CHANNELS-1:0]      gray_err
);

    localparam int            CW      = $clog2(STAGES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STAGES);
    localparam logic [CW-1:0] CNT_RDY = CW'(STAGES - 1);

    function automatic logic [SIZE-1:0] g2b(input logic [SIZE-1:0] g);
        logic [SIZE-1:0] b;
        b[SIZE-1] = g[SIZE-1];
        for (int i = SIZE - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync_ready_q, sync_ready_d;
    logic          armed_q;

    always_comb begin
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        sync_ready_d = (cnt_q == CNT_RDY) | sync_ready_q;
    end

    // The first sample after release reaches the output register one edge after
    // sync_ready rises; armed_q lags by that edge so it is taken as baseline, not an update.
    always_ff @(posedge dest_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sync_ready_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sync_ready_q <= sync_ready_d;
            armed_q      <= sync_ready_q;
        end
    end

    assign sync_ready = sync_ready_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SIZE-1:0] sync_q [STAGES];
        logic [SIZE-1:0] s;
        logic [SIZE-1:0] diff;
        logic [SIZE-1:0] prev_q;
        logic [SIZE-1:0] bin_q;
        logic [SIZE-1:0] delta_q, delta_d;
        logic            update_q, update_d;
        logic            err_q, err_d;
        logic            changed;
        logic            multi;

        assign s = sync_q[STAGES-1];

        always_comb begin
            diff     = s ^ prev_q;
            changed  = |diff;
            // Clearing the lowest set bit leaves something only if two or more bits flipped.
            multi    = |(diff & (diff - SIZE'(1)));
            update_d = armed_q & changed;
            delta_d  = (armed_q && changed) ? g2b(s) - g2b(prev_q) : '0;
            err_d    = (armed_q & multi) | (err_q & ~err_clr[gi]);
        end

        always_ff @(posedge dest_clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < STAGES; k++) begin
                    sync_q[k] <= '0;
                end
                prev_q   <= '0;
                bin_q    <= '0;
                delta_q  <= '0;
                update_q <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                sync_q[0] <= gray_in[gi*SIZE +: SIZE];
                for (int k = 1; k < STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
                prev_q   <= s;
                bin_q    <= g2b(s);
                delta_q  <= delta_d;
                update_q <= update_d;
                err_q    <= err_d;
            end
        end

        assign bin_out[gi*SIZE +: SIZE] = bin_q;
        assign delta[gi*SIZE +: SIZE]   = delta_q;
        assign update[gi]               = update_q;
        assign gray_err[gi]             = err_q;
    end

endmodule
